sync_scheduler: RTL

Parametrised successor of the single-outstanding FIFO-to-homography sync controller. Pops DVI pixel entries from a show-ahead input FIFO and issues pipelined coordinate queries to the homography engine, with up to DEPTH queries in flight. Pairs in-order engine returns with buffered DVI pixels and emits one synchronised DVI/CCD pixel per return. Adds a bypass mode, mismatch counting and protocol-error flagging.

---
 rtl/sync_scheduler.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/sync_scheduler.sv
// Pipelined FIFO-to-homography sync controller. Keeps up to DEPTH coordinate queries in flight and
// pairs in-order engine returns with buffered DVI pixels. A bypass mode copies DVI straight to CCD.
module sync_scheduler #(
  parameter int unsigned COORD_W = 10,
  parameter int unsigned IN_C_W  = 8,
  parameter int unsigned R_W     = 5,
  parameter int unsigned G_W     = 6,
  parameter int unsigned B_W     = 5,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                            clk_25,
  input  logic                            rst,
  input  logic [2*COORD_W+3*IN_C_W-1:0]   q,
  input  logic                            rdempty,
  output logic                            rdclk,
  output logic                            rdreq,
  input  logic                            bypass,
  output logic [COORD_W-1:0]              query_x,
  output logic [COORD_W-1:0]              query_y,
  output logic                            start,
  input  logic [COORD_W-1:0]              return_x,
  input  logic [COORD_W-1:0]              return_y,
  input  logic [R_W-1:0]                  r,
  input  logic [G_W-1:0]                  g,
  input  logic [B_W-1:0]                  b,
  input  logic                            ready,
  output logic                            val,
  output logic [COORD_W-1:0]              sync_x,
  output logic [COORD_W-1:0]              sync_y,
  output logic [R_W-1:0]                  dvi_r,
  output logic [G_W-1:0]                  dvi_g,
  output logic [B_W-1:0]                  dvi_b,
  output logic [R_W-1:0]                  ccd_r,
  output logic [G_W-1:0]                  ccd_g,
  output logic [B_W-1:0]                  ccd_b,
  output logic [$clog2(DEPTH):0]          outstanding,
  output logic [CNT_W-1:0]                mismatch_cnt,
  output logic                            debug,
  output logic                            proto_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned OW = AW + 1;
  localparam int unsigned CW3 = 3 * IN_C_W;
  localparam logic [AW:0] DepthCnt = OW'(DEPTH);

  typedef enum logic [1:0] {StRun, StDrain, StByp} state_e;

  state_e state_q;

  logic [COORD_W-1:0] q_x, q_y;
  logic [R_W-1:0]     q_r;
  logic [G_W-1:0]     q_g;
  logic [B_W-1:0]     q_b;
  logic               unused_q_lsbs;

  // Colour fields keep their MSBs; the dropped LSBs are deliberately ignored.
  assign q_x = q[CW3+COORD_W +: COORD_W];
  assign q_y = q[CW3 +: COORD_W];
  assign q_r = q[3*IN_C_W-1 -: R_W];
  assign q_g = q[2*IN_C_W-1 -: G_W];
  assign q_b = q[IN_C_W-1 -: B_W];
  assign unused_q_lsbs = ^q;

  logic [COORD_W-1:0] pend_x_q [DEPTH];
  logic [COORD_W-1:0] pend_y_q [DEPTH];
  logic [R_W-1:0]     pend_r_q [DEPTH];
  logic [G_W-1:0]     pend_g_q [DEPTH];
  logic [B_W-1:0]     pend_b_q [DEPTH];
  logic [AW-1:0]      head_q, tail_q;
  logic [AW:0]        outstanding_q;

  logic               start_q, val_q, debug_q, proto_err_q;
  logic [COORD_W-1:0] query_x_q, query_y_q, sync_x_q, sync_y_q;
  logic [R_W-1:0]     dvi_r_q, ccd_r_q;
  logic [G_W-1:0]     dvi_g_q, ccd_g_q;
  logic [B_W-1:0]     dvi_b_q, ccd_b_q;
  logic [CNT_W-1:0]   mismatch_cnt_q;

  logic ret, issue, byp_pop, head_mismatch;

  always_comb begin
    ret     = ready && (outstanding_q != '0);
    issue   = 1'b0;
    byp_pop = 1'b0;
    if (!rst && !rdempty) begin
      case (state_q)
        // A return in the same cycle frees a slot, so a full buffer can still issue.
        StRun:   issue = !bypass && ((outstanding_q < DepthCnt) || ret);
        StByp:   byp_pop = bypass;
        default: ;
      endcase
    end
  end

  assign head_mismatch = (pend_x_q[head_q] != return_x) || (pend_y_q[head_q] != return_y);

  assign rdclk = clk_25;
  assign rdreq = issue | byp_pop;

  always_ff @(posedge clk_25) begin
    if (issue) begin
      pend_x_q[tail_q] <= q_x;
      pend_y_q[tail_q] <= q_y;
      pend_r_q[tail_q] <= q_r;
      pend_g_q[tail_q] <= q_g;
      pend_b_q[tail_q] <= q_b;
    end
  end

  always_ff @(posedge clk_25) begin
    if (rst) begin
      state_q        <= StRun;
      head_q         <= '0;
      tail_q         <= '0;
      outstanding_q  <= '0;
      start_q        <= 1'b0;
      val_q          <= 1'b0;
      query_x_q      <= '0;
      query_y_q      <= '0;
      sync_x_q       <= '0;
      sync_y_q       <= '0;
      dvi_r_q        <= '0;
      dvi_g_q        <= '0;
      dvi_b_q        <= '0;
      ccd_r_q        <= '0;
      ccd_g_q        <= '0;
      ccd_b_q        <= '0;
      mismatch_cnt_q <= '0;
      debug_q        <= 1'b0;
      proto_err_q    <= 1'b0;
    end else begin
      start_q <= issue;
      val_q   <= ret | byp_pop;

      if (issue) begin
        query_x_q <= q_x;
        query_y_q <= q_y;
        tail_q    <= tail_q + AW'(1);
      end

      if (ret) begin
        head_q   <= head_q + AW'(1);
        sync_x_q <= return_x;
        sync_y_q <= return_y;
        dvi_r_q  <= pend_r_q[head_q];
        dvi_g_q  <= pend_g_q[head_q];
        dvi_b_q  <= pend_b_q[head_q];
        ccd_r_q  <= r;
        ccd_g_q  <= g;
        ccd_b_q  <= b;
        if (head_mismatch) begin
          debug_q <= 1'b1;
          if (mismatch_cnt_q != '1) begin
            mismatch_cnt_q <= mismatch_cnt_q + CNT_W'(1);
          end
        end
      end else if (ready) begin
        proto_err_q <= 1'b1;
      end

      if (byp_pop) begin
        sync_x_q <= q_x;
        sync_y_q <= q_y;
        dvi_r_q  <= q_r;
        dvi_g_q  <= q_g;
        dvi_b_q  <= q_b;
        ccd_r_q  <= q_r;
        ccd_g_q  <= q_g;
        ccd_b_q  <= q_b;
      end

      case ({issue, ret})
        2'b10:   outstanding_q <= outstanding_q + OW'(1);
        2'b01:   outstanding_q <= outstanding_q - OW'(1);
        default: ;
      endcase

      case (state_q)
        StRun:   if (bypass) state_q <= StDrain;
        StDrain: begin
          if (!bypass) begin
            state_q <= StRun;
          end else if (outstanding_q == '0) begin
            state_q <= StByp;
          end
        end
        StByp:   if (!bypass) state_q <= StRun;
        default: state_q <= StRun;
      endcase
    end
  end

  assign query_x      = query_x_q;
  assign query_y      = query_y_q;
  assign start        = start_q;
  assign val          = val_q;
  assign sync_x       = sync_x_q;
  assign sync_y       = sync_y_q;
  assign dvi_r        = dvi_r_q;
  assign dvi_g        = dvi_g_q;
  assign dvi_b        = dvi_b_q;
  assign ccd_r        = ccd_r_q;
  assign ccd_g        = ccd_g_q;
  assign ccd_b        = ccd_b_q;
  assign outstanding  = outstanding_q;
  assign mismatch_cnt = mismatch_cnt_q;
  assign debug        = debug_q;
  assign proto_err    = proto_err_q;

endmodule
